frac_baud_gen: RTL and testbench
================================

FRAC_BAUD_GEN -- requirements
Module: frac_baud_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: integer divisor width.
REQ-002 SHALL have parameter FRAC_W, default 4: fractional divisor width, legal range 1..8.
REQ-003 SHALL have parameter OVERSAMPLE, default 16: oversample ticks per baud, a power of two, at least 4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: advances the counters when high.
REQ-007 SHALL have port restart, input, 1 bit: resynchronises the counters to the start of a baud period.
REQ-008 SHALL have port div_int, input, DIV_W bits: integer part of the oversample period, in clk cycles.
REQ-009 SHALL have port div_frac, input, FRAC_W bits: fractional part of the oversample period, in units of 1/2^FRAC_W.
REQ-010 SHALL have port cfg_load, input, 1 bit: one-cycle pulse that captures div_int and div_frac into a pending register.
REQ-011 SHALL have port os_tick, output, 1 bit: oversample tick.
REQ-012 SHALL have port baud_tick, output, 1 bit: end of a baud period.
REQ-013 SHALL have port half_baud_tick, output, 1 bit: mid-bit sample point.
REQ-014 SHALL have port os_phase, output, $clog2(OVERSAMPLE) bits: current oversample index within the bit.
REQ-015 SHALL have port cfg_pending, output, 1 bit: high while a captured divisor is waiting to be applied.

Function
REQ-016 SHALL define the effective integer divisor E as max(act_int, 1); act_int = 0 behaves exactly as act_int = 1.
REQ-017 SHALL hold these state registers: down-counter cnt (DIV_W bits), fractional accumulator acc (FRAC_W bits), phase counter, active divisor act_int/act_frac, pending divisor pend_int/pend_frac, and flag pend.
REQ-018 SHALL drive os_tick = enable & !reset & (cnt == 0), with no register delay.
REQ-019 SHALL, on an os_tick, form {carry, acc_next} = acc + act_frac, update acc to acc_next, and reload cnt to E - 1 + carry; otherwise, while enable is high, decrement cnt.
REQ-020 SHALL make the long-run mean os_tick period exactly act_int + act_frac/2^FRAC_W cycles for act_int >= 1; each individual interval is E or E+1 cycles.
REQ-021 SHALL advance phase by one on each os_tick, wrapping from OVERSAMPLE-1 to 0; os_phase equals phase.
REQ-022 SHALL drive baud_tick = os_tick & (phase == OVERSAMPLE-1).
REQ-023 SHALL drive half_baud_tick = os_tick & (phase == OVERSAMPLE/2-1).
REQ-024 SHALL hold cnt, acc and phase while enable is low, with all ticks forced to 0.
REQ-025 SHALL, on restart, load cnt to E - 1 and clear acc and phase, so the first os_tick occurs E cycles after the restart cycle; restart overrides enable.
REQ-026 SHALL, on cfg_load, capture div_int and div_frac into pend_int/pend_frac and set pend.
REQ-027 SHALL apply the pending divisor to act_int/act_frac and clear pend at the first "apply point", defined as any cycle with baud_tick, restart, or enable low.
REQ-028 SHALL use the newly applied divisor for the cnt reload or restart load made in that same cycle.
REQ-029 SHALL, when cfg_load coincides with an apply point, apply div_int/div_frac directly and leave pend clear.
REQ-030 SHALL, when cfg_load repeats before an apply point, overwrite the pending values (last load wins).
REQ-031 SHALL drive cfg_pending = pend.

Reset
REQ-032 SHALL, on reset, load act_int/act_frac from div_int/div_frac, set cnt to E - 1, and clear acc, phase and pend.
REQ-033 SHALL hold all tick outputs, os_phase and cfg_pending at 0 while reset is high; reset overrides restart, cfg_load and enable.

Structure
REQ-034 SHALL take the default parameter values and the OVERSAMPLE legality check (elaboration-time assertion) from the shared package uart_pkg.
REQ-035 SHALL be a single module with no sub-modules; accumulator and counters are inline.

Verification
REQ-036 SHALL cover: div_int=4, div_frac=0, restart at cycle 0 -> os_tick at cycles 4, 8, ...; half_baud_tick at 32; baud_tick at 64; os_phase = 15 at cycle 64.
REQ-037 SHALL cover: div_int=4, div_frac=8 -> intervals 4, 4, 5, 4, 5, ...; the 16 intervals after the first sum to exactly 72 cycles.
REQ-038 SHALL cover: while running at div_int=4, cfg_load div_int=2 at cycle 10 -> os period stays 4 until baud_tick at 64; cfg_pending is high for cycles 11..64; the next os_tick is at 66.
REQ-039 SHALL cover: enable low for 10 cycles mid-interval -> no ticks while low; the next os_tick is exactly 10 cycles later than nominal.
REQ-040 SHALL cover: div_int=0 -> os_tick every cycle and baud_tick every 16 cycles; also reset asserted mid-baud -> all outputs 0 in the following cycle, and after release the first os_tick comes E cycles later.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART timing blocks.
//   Provides default parameter values for the fractional baud generator and a
//   legality check for the oversample ratio that is used at elaboration time.
//   No ports.
package uart_pkg;

    localparam int unsigned DIV_W_DEFAULT      = 16;
    localparam int unsigned FRAC_W_DEFAULT     = 4;
    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    // Oversample ratio must be a power of two and at least 4 so that the
    // phase counter wraps naturally and a mid-bit point exists.
    function automatic bit oversample_ok(input int unsigned os);
        return (os >= 4) && ((os & (os - 1)) == 0);
    endfunction

endpackage

// File: rtl/frac_baud_gen.sv
// frac_baud_gen
//   Fractional oversample/baud tick generator. A down-counter produces an
//   oversample tick every E or E+1 cycles (E = max(act_int,1)); a fractional
//   accumulator adds the extra cycle often enough that the mean period is
//   act_int + act_frac/2^FRAC_W. A phase counter divides the oversample ticks
//   into baud periods. New divisors are staged in a pending register and
//   applied only at a baud boundary, a restart, or while disabled.
//
// Ports
//   clk            : clock, all logic on rising edge
//   reset          : synchronous active-high reset
//   enable         : advances counters when high
//   restart        : resynchronise to the start of a baud period
//   div_int        : integer part of oversample period (clk cycles)
//   div_frac       : fractional part of oversample period (1/2^FRAC_W units)
//   cfg_load       : pulse, captures div_int/div_frac
//   os_tick        : oversample tick
//   baud_tick      : end of baud period
//   half_baud_tick : mid-bit sample point
//   os_phase       : oversample index within the bit
//   cfg_pending    : a captured divisor is waiting to be applied
module frac_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W      = DIV_W_DEFAULT,
    parameter int unsigned FRAC_W     = FRAC_W_DEFAULT,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          restart,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          cfg_load,
    output logic                          os_tick,
    output logic                          baud_tick,
    output logic                          half_baud_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          cfg_pending
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);

    if (!oversample_ok(OVERSAMPLE)) begin : g_bad_oversample
        $error("frac_baud_gen: OVERSAMPLE must be a power of two and >= 4");
    end
    if (FRAC_W < 1 || FRAC_W > 8) begin : g_bad_frac_w
        $error("frac_baud_gen: FRAC_W must be in 1..8");
    end

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [PH_W-1:0]   phase;
    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  pend_int;
    logic [FRAC_W-1:0] pend_frac;
    logic              pend;

    logic              apply;
    logic [DIV_W-1:0]  new_int;
    logic [FRAC_W-1:0] new_frac;
    logic [DIV_W-1:0]  eff_div;
    logic [DIV_W-1:0]  rst_div;
    logic [FRAC_W-1:0] acc_next;
    logic              carry;

    always_comb begin
        os_tick        = enable & ~reset & (cnt == '0);
        baud_tick      = os_tick & (phase == PH_W'(OVERSAMPLE - 1));
        half_baud_tick = os_tick & (phase == PH_W'(OVERSAMPLE / 2 - 1));
        os_phase       = reset ? '0 : phase;
        cfg_pending    = pend & ~reset;

        // The divisor in force for this cycle's reload: a load landing on an
        // apply point bypasses the pending register entirely.
        apply    = baud_tick | restart | ~enable;
        new_int  = act_int;
        new_frac = act_frac;
        if (apply && cfg_load) begin
            new_int  = div_int;
            new_frac = div_frac;
        end else if (apply && pend) begin
            new_int  = pend_int;
            new_frac = pend_frac;
        end

        eff_div = (new_int == '0) ? DIV_W'(1) : new_int;
        rst_div = (div_int == '0) ? DIV_W'(1) : div_int;
        {carry, acc_next} = {1'b0, acc} + {1'b0, new_frac};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_int   <= div_int;
            act_frac  <= div_frac;
            pend_int  <= '0;
            pend_frac <= '0;
            pend      <= 1'b0;
            cnt       <= rst_div - 1'b1;
            acc       <= '0;
            phase     <= '0;
        end else begin
            if (apply) begin
                act_int  <= new_int;
                act_frac <= new_frac;
                pend     <= 1'b0;
            end else if (cfg_load) begin
                pend_int  <= div_int;
                pend_frac <= div_frac;
                pend      <= 1'b1;
            end

            if (restart) begin
                cnt   <= eff_div - 1'b1;
                acc   <= '0;
                phase <= '0;
            end else if (enable) begin
                if (cnt == '0) begin
                    cnt   <= eff_div - 1'b1 + DIV_W'(carry);
                    acc   <= acc_next;
                    phase <= phase + 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frac_baud_gen.sv
// tb_frac_baud_gen
//   Self-checking bench for frac_baud_gen. A behavioural model tracks tick
//   timing as "enabled cycles waited versus cycles needed", with the extra
//   cycle derived from an unbounded running sum of fractional parts, and is
//   compared against every output on every cycle. Directed scenarios pin the
//   model with hand-computed tick positions; a randomized phase follows.
module tb_frac_baud_gen;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              restart;
    logic              cfg_load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              os_tick;
    logic              baud_tick;
    logic              half_baud_tick;
    logic [3:0]        os_phase;
    logic              cfg_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frac_baud_gen #(
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W),
        .OVERSAMPLE (OS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .restart        (restart),
        .div_int        (div_int),
        .div_frac       (div_frac),
        .cfg_load       (cfg_load),
        .os_tick        (os_tick),
        .baud_tick      (baud_tick),
        .half_baud_tick (half_baud_tick),
        .os_phase       (os_phase),
        .cfg_pending    (cfg_pending)
    );

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // ---------------- behavioural model, compared every cycle ----------------
    int     m_need, m_wait, m_ticks;
    int     m_act_i, m_act_f, m_pend_i, m_pend_f;
    bit     m_pend;
    bit     m_live = 1'b0;
    longint m_fsum;

    always @(negedge clk) begin
        bit e_os, e_baud, e_half, apply;
        int e_phase, ni, nf, eff, carry;
        if (reset) begin
            chk("rst_os_tick", os_tick, 0);
            chk("rst_baud_tick", baud_tick, 0);
            chk("rst_half_tick", half_baud_tick, 0);
            chk("rst_os_phase", os_phase, 0);
            chk("rst_cfg_pending", cfg_pending, 0);
            m_live  = 1'b1;
            m_act_i = int'(div_int);
            m_act_f = int'(div_frac);
            m_pend  = 1'b0;
            m_need  = (div_int == 0) ? 1 : int'(div_int);
            m_wait  = 0;
            m_fsum  = 0;
            m_ticks = 0;
        end else if (m_live) begin
            e_os    = enable && (m_wait == m_need - 1);
            e_phase = m_ticks % OS;
            e_baud  = e_os && (e_phase == OS - 1);
            e_half  = e_os && (e_phase == OS / 2 - 1);
            chk("os_tick", os_tick, e_os);
            chk("baud_tick", baud_tick, e_baud);
            chk("half_baud_tick", half_baud_tick, e_half);
            chk("os_phase", os_phase, e_phase);
            chk("cfg_pending", cfg_pending, m_pend);

            apply = e_baud || restart || !enable;
            ni = m_act_i;
            nf = m_act_f;
            if (apply) begin
                if (cfg_load) begin
                    ni = int'(div_int);
                    nf = int'(div_frac);
                end else if (m_pend) begin
                    ni = m_pend_i;
                    nf = m_pend_f;
                end
                m_act_i = ni;
                m_act_f = nf;
                m_pend  = 1'b0;
            end else if (cfg_load) begin
                m_pend   = 1'b1;
                m_pend_i = int'(div_int);
                m_pend_f = int'(div_frac);
            end
            eff = (ni == 0) ? 1 : ni;

            if (restart) begin
                m_need  = eff;
                m_wait  = 0;
                m_fsum  = 0;
                m_ticks = 0;
            end else if (enable) begin
                if (e_os) begin
                    carry   = int'(((m_fsum + nf) >> FRAC_W) - (m_fsum >> FRAC_W));
                    m_fsum  = m_fsum + nf;
                    m_need  = eff + carry;
                    m_wait  = 0;
                    m_ticks = m_ticks + 1;
                end else begin
                    m_wait = m_wait + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic       s_os, s_baud, s_half, s_pend;
    logic [3:0] s_phase;

    // Let the current inputs act for one cycle, sampling outputs mid-cycle.
    task automatic nxt();
        @(negedge clk);
        s_os    = os_tick;
        s_baud  = baud_tick;
        s_half  = half_baud_tick;
        s_pend  = cfg_pending;
        s_phase = os_phase;
        @(posedge clk);
        #1;
    endtask

    // Restart with a divisor loaded on the same cycle (applied directly).
    task automatic start(input int di, input int df);
        div_int  = DIV_W'(di);
        div_frac = FRAC_W'(df);
        cfg_load = 1'b1;
        restart  = 1'b1;
        enable   = 1'b1;
        nxt();
        cfg_load = 1'b0;
        restart  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_os, half_c, baud_c, ph64, nticks, idx, stall_ticks, pend_bad, os60, pend40;
        int t[17];

        reset    = 1'b1;
        enable   = 1'b1;
        restart  = 1'b1;
        cfg_load = 1'b1;
        div_int  = 16'd4;
        div_frac = 4'd0;
        nxt();
        chk("reset_os", s_os, 0);
        chk("reset_phase", s_phase, 0);
        chk("reset_pending", s_pend, 0);
        nxt();
        reset    = 1'b0;
        cfg_load = 1'b0;

        // Integer divisor 4: ticks every 4, half at 32, baud at 64.
        restart = 1'b1;
        nxt();
        restart = 1'b0;
        first_os = -1; half_c = -1; baud_c = -1; ph64 = -1; nticks = 0;
        for (int c = 1; c <= 70; c++) begin
            nxt();
            if (s_os && first_os < 0) first_os = c;
            if (s_half && half_c < 0) half_c = c;
            if (s_baud && baud_c < 0) baud_c = c;
            if (c == 64) ph64 = s_phase;
            if (s_os && c <= 64) nticks++;
        end
        chk("int4_first_os", first_os, 4);
        chk("int4_half", half_c, 32);
        chk("int4_baud", baud_c, 64);
        chk("int4_phase_at_64", ph64, 15);
        chk("int4_ticks_to_64", nticks, 16);

        // Divisor 4.5: intervals 4,4,5,4,5..., 16 intervals after first = 72.
        start(4, 8);
        for (int i = 0; i < 17; i++) t[i] = -1000;
        idx = 0;
        for (int c = 1; c <= 200 && idx < 17; c++) begin
            nxt();
            if (s_os) begin
                t[idx] = c;
                idx++;
            end
        end
        chk("frac_first", t[0], 4);
        chk("frac_int2", t[1] - t[0], 4);
        chk("frac_int3", t[2] - t[1], 5);
        chk("frac_int4", t[3] - t[2], 4);
        chk("frac_sum16", t[16] - t[0], 72);

        // Pending divisor held until the baud boundary.
        start(4, 0);
        pend_bad = 0; baud_c = -1; first_os = -1; os60 = -1;
        for (int c = 1; c <= 80; c++) begin
            cfg_load = (c == 10);
            div_int  = (c == 10) ? 16'd2 : 16'd4;
            nxt();
            if (s_pend != (c >= 11 && c <= 64)) pend_bad++;
            if (s_baud && baud_c < 0) baud_c = c;
            if (s_os && c > 64 && first_os < 0) first_os = c;
            if (c == 60) os60 = s_os;
        end
        cfg_load = 1'b0;
        chk("pend_window", pend_bad, 0);
        chk("pend_baud", baud_c, 64);
        chk("pend_old_period", os60, 1);
        chk("pend_new_first", first_os, 66);

        // Enable low for 10 cycles mid-interval delays the next tick by 10.
        start(4, 0);
        stall_ticks = 0; first_os = -1;
        for (int c = 1; c <= 40; c++) begin
            enable = !(c >= 10 && c <= 19);
            nxt();
            if (s_os && c >= 10 && c <= 19) stall_ticks++;
            if (s_os && c >= 10 && first_os < 0) first_os = c;
        end
        enable = 1'b1;
        chk("stall_no_ticks", stall_ticks, 0);
        chk("stall_next_os", first_os, 22);

        // Divisor 0 behaves as 1; then reset mid-baud with a load pending.
        start(0, 0);
        nticks = 0; idx = 0; baud_c = -1; pend40 = -1;
        for (int c = 1; c <= 40; c++) begin
            cfg_load = (c == 39);
            div_int  = (c == 39) ? 16'd3 : 16'd0;
            nxt();
            if (s_os && c <= 32) nticks++;
            if (s_baud && c <= 32) idx++;
            if (s_baud && baud_c < 0) baud_c = c;
            if (c == 40) pend40 = s_pend;
        end
        cfg_load = 1'b0;
        chk("div0_os_count", nticks, 32);
        chk("div0_baud_count", idx, 2);
        chk("div0_first_baud", baud_c, 16);
        chk("div0_pend_before_reset", pend40, 1);

        div_int = 16'd4;
        reset   = 1'b1;
        for (int r = 0; r < 2; r++) begin
            nxt();
            chk("midrst_os", s_os, 0);
            chk("midrst_baud", s_baud, 0);
            chk("midrst_half", s_half, 0);
            chk("midrst_phase", s_phase, 0);
            chk("midrst_pend", s_pend, 0);
        end
        reset = 1'b0;
        first_os = -1;
        for (int c = 1; c <= 20; c++) begin
            nxt();
            if (s_os && first_os < 0) first_os = c;
        end
        chk("post_reset_first_os", first_os, 4);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 19) != 0);
            restart  = ($urandom_range(0, 149) == 0);
            cfg_load = ($urandom_range(0, 39) == 0);
            div_int  = DIV_W'($urandom_range(0, 6));
            div_frac = FRAC_W'($urandom_range(0, 15));
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
